// File: rtl/iiq_pkg.sv
// Shared definitions for the integer issue queue: ROB/data widths, the
// entry layout carried from dispatch to the ALU, and operand wakeup helpers.
package iiq_pkg;

  localparam int ROB_ID_WIDTH = 6;

  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [31:0]             reg_data_t;
  typedef logic [3:0]              alu_ctrl_t;

  typedef struct packed {
    logic      valid;
    rob_id_t   rob_id;
    logic      ready;
    reg_data_t data;
  } iiq_src_t;

  typedef struct packed {
    iiq_src_t  src1;
    iiq_src_t  src2;
    logic      dst_valid;
    rob_id_t   instr_rob_id;
    alu_ctrl_t alu_ctrl;
    logic [31:0] pc;
    logic      br_dir_pred;
    logic [31:0] br_target_pred;
  } iiq_entry_t;

  // A source that does not exist never blocks issue.
  function automatic logic src_ok(iiq_src_t s);
    return !s.valid || s.ready;
  endfunction

  function automatic logic entry_ready(iiq_entry_t e);
    return src_ok(e.src1) && src_ok(e.src2);
  endfunction

  // Only a pending source can be woken; data-carrying broadcasts also
  // capture the value, the speculative wakeup only marks it ready.
  function automatic iiq_src_t wake_src(iiq_src_t s,
                                        logic iw_v, rob_id_t iw_id,
                                        logic ab_v, rob_id_t ab_id, reg_data_t ab_d,
                                        logic lb_v, rob_id_t lb_id, reg_data_t lb_d);
    iiq_src_t r;
    r = s;
    if (s.valid && !s.ready) begin
      if (lb_v && (lb_id == s.rob_id)) begin
        r.ready = 1'b1;
        r.data  = lb_d;
      end else if (ab_v && (ab_id == s.rob_id)) begin
        r.ready = 1'b1;
        r.data  = ab_d;
      end else if (iw_v && (iw_id == s.rob_id)) begin
        r.ready = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic iiq_entry_t wake_entry(iiq_entry_t e,
                                            logic iw_v, rob_id_t iw_id,
                                            logic ab_v, rob_id_t ab_id, reg_data_t ab_d,
                                            logic lb_v, rob_id_t lb_id, reg_data_t lb_d);
    iiq_entry_t r;
    r = e;
    r.src1 = wake_src(e.src1, iw_v, iw_id, ab_v, ab_id, ab_d, lb_v, lb_id, lb_d);
    r.src2 = wake_src(e.src2, iw_v, iw_id, ab_v, ab_id, ab_d, lb_v, lb_id, lb_d);
    return r;
  endfunction

endpackage

// File: rtl/iiq_if.sv
// Bundle of all issue-queue facing signals: dispatch handshake, ALU issue
// handshake, speculative wakeup, result broadcasts and flush requests.
// slave = the issue queue, master = its environment.
interface iiq_if;
  import iiq_pkg::*;

  logic       iiq_dispatch_ready;
  logic       iiq_dispatch_valid;
  iiq_entry_t iiq_dispatch_data;

  logic       iiq_wakeup_valid;
  rob_id_t    iiq_wakeup_rob_id;

  logic       alu_issue_ready;
  logic       alu_issue_valid;
  iiq_entry_t alu_issue_data;

  logic       alu_broadcast_valid;
  rob_id_t    alu_broadcast_rob_id;
  reg_data_t  alu_broadcast_reg_data;

  logic       ld_broadcast_valid;
  rob_id_t    ld_broadcast_rob_id;
  reg_data_t  ld_broadcast_reg_data;

  logic       alu_br_mispred;
  logic       ld_mispred;

  modport slave (
    output iiq_dispatch_ready,
    input  iiq_dispatch_valid, iiq_dispatch_data,
    output iiq_wakeup_valid, iiq_wakeup_rob_id,
    input  alu_issue_ready,
    output alu_issue_valid, alu_issue_data,
    input  alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
    input  ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data,
    input  alu_br_mispred, ld_mispred
  );

  modport master (
    input  iiq_dispatch_ready,
    output iiq_dispatch_valid, iiq_dispatch_data,
    input  iiq_wakeup_valid, iiq_wakeup_rob_id,
    output alu_issue_ready,
    input  alu_issue_valid, alu_issue_data,
    output alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
    output ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data,
    output alu_br_mispred, ld_mispred
  );

endinterface

// File: rtl/iiq_select.sv
// Lowest-index priority picker: one-hot grant of the least significant
// request bit, plus a flag saying whether any request was present.
module iiq_select #(
  parameter int N_ENTRIES = 8
) (
  input  logic [N_ENTRIES-1:0] req_i,
  output logic [N_ENTRIES-1:0] grant_o,
  output logic                 found_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant_o = req_i & (~req_i + N_ENTRIES'(1));
  assign found_o = |req_i;

endmodule

// File: rtl/iiq.sv
// Integer issue queue. Compacting array (slot 0 oldest), oldest-ready
// select, one issue per cycle, operand wakeup from ALU/load broadcasts.
// Build option IIQ_SPEC_WAKEUP_EN: when defined, the issuing instruction
// also drives a speculative wakeup so a dependent can issue back-to-back.
module iiq
  import iiq_pkg::*;
#(
  parameter int N_ENTRIES = 8
) (
  input  logic clk,
  input  logic rst_aL,
  iiq_if.slave bus
);

  localparam int CNT_W = $clog2(N_ENTRIES + 1);

  iiq_entry_t           slot_q [N_ENTRIES];
  iiq_entry_t           slot_d [N_ENTRIES];
  iiq_entry_t           woken  [N_ENTRIES];
  iiq_entry_t           in_woken;
  logic [CNT_W-1:0]     count_q, count_d, wr_idx;
  logic [N_ENTRIES-1:0] req, grant, prefix;
  logic                 found, flush, accept, issue;
  logic                 iw_valid;
  rob_id_t              iw_rob_id;
  iiq_entry_t           sel, issue_data;

  assign flush  = bus.alu_br_mispred || bus.ld_mispred;
  assign bus.iiq_dispatch_ready = (count_q < CNT_W'(N_ENTRIES)) && !flush;
  assign accept = bus.iiq_dispatch_valid && bus.iiq_dispatch_ready;

  // Per-slot request and "at or above the granted slot" mask for compaction.
  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_slot
    assign req[gi]    = (CNT_W'(gi) < count_q) && entry_ready(slot_q[gi]);
    assign prefix[gi] = |grant[gi:0];
  end

  iiq_select #(.N_ENTRIES(N_ENTRIES)) u_select (
    .req_i   (req),
    .grant_o (grant),
    .found_o (found)
  );

  // One-hot mux of the granted slot.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (grant[i]) sel = slot_q[i];
    end
  end

  assign bus.alu_issue_valid = found && !flush;
  assign issue = bus.alu_issue_valid && bus.alu_issue_ready;

`ifdef IIQ_SPEC_WAKEUP_EN
  assign iw_valid  = issue && sel.dst_valid;
  assign iw_rob_id = sel.instr_rob_id;
`else
  assign iw_valid  = 1'b0;
  assign iw_rob_id = '0;
`endif

  assign bus.iiq_wakeup_valid  = iw_valid;
  assign bus.iiq_wakeup_rob_id = iw_rob_id;

  // Issue payload, with a same-cycle ALU result bypassed into each source.
  always_comb begin
    issue_data = '0;
    if (found) begin
      issue_data = sel;
      if (bus.alu_broadcast_valid && (bus.alu_broadcast_rob_id == sel.src1.rob_id))
        issue_data.src1.data = bus.alu_broadcast_reg_data;
      if (bus.alu_broadcast_valid && (bus.alu_broadcast_rob_id == sel.src2.rob_id))
        issue_data.src2.data = bus.alu_broadcast_reg_data;
    end
  end

  assign bus.alu_issue_data = issue_data;

  assign in_woken = wake_entry(bus.iiq_dispatch_data, iw_valid, iw_rob_id,
                               bus.alu_broadcast_valid, bus.alu_broadcast_rob_id,
                               bus.alu_broadcast_reg_data,
                               bus.ld_broadcast_valid, bus.ld_broadcast_rob_id,
                               bus.ld_broadcast_reg_data);

  // The new entry lands just past the surviving entries.
  assign wr_idx = issue ? (count_q - CNT_W'(1)) : count_q;

  // Next slot contents: wake, shift down over the issued slot, append.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      woken[i] = wake_entry(slot_q[i], iw_valid, iw_rob_id,
                            bus.alu_broadcast_valid, bus.alu_broadcast_rob_id,
                            bus.alu_broadcast_reg_data,
                            bus.ld_broadcast_valid, bus.ld_broadcast_rob_id,
                            bus.ld_broadcast_reg_data);
    end
    for (int i = 0; i < N_ENTRIES; i++) begin
      slot_d[i] = (issue && prefix[i]) ? woken[(i < N_ENTRIES - 1) ? i + 1 : i] : woken[i];
      if (accept && (wr_idx == CNT_W'(i))) slot_d[i] = in_woken;
    end
  end

  // Occupancy moves by at most one per cycle; a flush empties the queue.
  always_comb begin
    count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
    if (flush) count_d = '0;
  end

  // Occupancy register; slots beyond it are don't-care, so only it resets.
  always_ff @(posedge clk) begin
    if (!rst_aL) count_q <= '0;
    else         count_q <= count_d;
  end

  // Slot payload storage.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: tb/tb_iiq.sv
// Directed bench for iiq: stimulus pushes expected issues (rob_id, operand
// data, wakeup, issue cycle) into a scoreboard; a negedge monitor pops and
// compares every accepted issue. Level checks cover reset, full and flush.
module tb_iiq;
  import iiq_pkg::*;

`ifdef IIQ_SPEC_WAKEUP_EN
  localparam bit SPEC = 1'b1;
`else
  localparam bit SPEC = 1'b0;
`endif

  typedef struct {
    int          rob;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        wake;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   t;

  iiq_if bus();

  iiq #(.N_ENTRIES(8)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int rob, logic [31:0] s1, logic [31:0] s2, logic dst, int c);
    exp_t e;
    e.rob = rob; e.s1 = s1; e.s2 = s2; e.wake = SPEC && dst; e.cyc = c;
    sb.push_back(e);
  endtask

  function automatic iiq_entry_t mk(int rob, logic dst,
                                    logic s1v, int s1id, logic s1r, logic [31:0] s1d,
                                    logic s2v, int s2id, logic s2r, logic [31:0] s2d);
    iiq_entry_t e;
    e = '0;
    e.instr_rob_id = rob_id_t'(rob);
    e.dst_valid    = dst;
    e.src1.valid   = s1v; e.src1.rob_id = rob_id_t'(s1id); e.src1.ready = s1r; e.src1.data = s1d;
    e.src2.valid   = s2v; e.src2.rob_id = rob_id_t'(s2id); e.src2.ready = s2r; e.src2.data = s2d;
    e.pc           = 32'h1000 + 32'(rob);
    e.alu_ctrl     = 4'(rob);
    return e;
  endfunction

  // Scoreboard monitor: every accepted issue must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_aL && bus.alu_issue_valid && bus.alu_issue_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: got rob %0d, required no issue (cycle %0d)",
                 bus.alu_issue_data.instr_rob_id, cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("issue rob=%0d s1=0x%0h s2=0x%0h wake=%0b cycle=%0d",
                 bus.alu_issue_data.instr_rob_id, bus.alu_issue_data.src1.data,
                 bus.alu_issue_data.src2.data, bus.iiq_wakeup_valid, cyc);
        check("issue_rob", 64'(bus.alu_issue_data.instr_rob_id), 64'(mon_e.rob));
        check("issue_src1", 64'(bus.alu_issue_data.src1.data), 64'(mon_e.s1));
        check("issue_src2", 64'(bus.alu_issue_data.src2.data), 64'(mon_e.s2));
        check("issue_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("wakeup_valid", 64'(bus.iiq_wakeup_valid), 64'(mon_e.wake));
        check("wakeup_rob", 64'(bus.iiq_wakeup_rob_id), SPEC ? 64'(mon_e.rob) : 64'd0);
      end
    end
  end

  initial begin
    bus.iiq_dispatch_valid     = 1'b0;
    bus.iiq_dispatch_data      = '0;
    bus.alu_issue_ready        = 1'b0;
    bus.alu_broadcast_valid    = 1'b0;
    bus.alu_broadcast_rob_id   = '0;
    bus.alu_broadcast_reg_data = '0;
    bus.ld_broadcast_valid     = 1'b0;
    bus.ld_broadcast_rob_id    = '0;
    bus.ld_broadcast_reg_data  = '0;
    bus.alu_br_mispred         = 1'b0;
    bus.ld_mispred             = 1'b0;

    // Reset state
    step(); step();
    rst_aL = 1'b1;
    @(negedge clk);
    check("rst_dispatch_ready", 64'(bus.iiq_dispatch_ready), 64'd1);
    check("rst_issue_valid", 64'(bus.alu_issue_valid), 64'd0);
    check("rst_wakeup_valid", 64'(bus.iiq_wakeup_valid), 64'd0);
    check("rst_wakeup_rob", 64'(bus.iiq_wakeup_rob_id), 64'd0);
    check("rst_issue_data_nonzero", 64'(|bus.alu_issue_data), 64'd0);

    // Fill 8 independent entries with the ALU stalled, then drain in order
    for (int k = 0; k < 8; k++) begin
      step();
      bus.iiq_dispatch_valid = 1'b1;
      bus.iiq_dispatch_data  = mk(k, 1'b1, 1'b0, 63, 1'b0, 32'h100 + 32'(k),
                                  1'b0, 63, 1'b0, 32'h200 + 32'(k));
      @(negedge clk);
      check("fill_ready", 64'(bus.iiq_dispatch_ready), 64'd1);
    end
    step();
    bus.iiq_dispatch_valid = 1'b0;
    @(negedge clk);
    check("full_ready", 64'(bus.iiq_dispatch_ready), 64'd0);
    check("stalled_valid", 64'(bus.alu_issue_valid), 64'd1);
    step();
    t = cyc;
    for (int k = 0; k < 8; k++) push(k, 32'h100 + 32'(k), 32'h200 + 32'(k), 1'b1, t + k);
    bus.alu_issue_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("drained_valid", 64'(bus.alu_issue_valid), 64'd0);
    check("drained_ready", 64'(bus.iiq_dispatch_ready), 64'd1);

    // Producer rob 3 -> consumer src1 rob 3; ALU result 0x55 at producer issue+1
    step();
    t = cyc;
    bus.iiq_dispatch_valid = 1'b1;
    bus.iiq_dispatch_data  = mk(3, 1'b1, 1'b0, 63, 1'b0, 32'h31, 1'b0, 63, 1'b0, 32'h32);
    push(3, 32'h31, 32'h32, 1'b1, t + 1);
    step();
    bus.iiq_dispatch_data  = mk(10, 1'b0, 1'b1, 3, 1'b0, 32'h0, 1'b0, 63, 1'b0, 32'hC2);
    push(10, 32'h55, 32'hC2, 1'b0, t + (SPEC ? 2 : 3));
    step();
    bus.iiq_dispatch_valid     = 1'b0;
    bus.alu_broadcast_valid    = 1'b1;
    bus.alu_broadcast_rob_id   = rob_id_t'(3);
    bus.alu_broadcast_reg_data = 32'h55;
    step();
    bus.alu_broadcast_valid    = 1'b0;
    step(); step();

    // Load wakeup of src2 rob 5 with 0xDEAD
    step();
    t = cyc;
    bus.iiq_dispatch_valid = 1'b1;
    bus.iiq_dispatch_data  = mk(20, 1'b1, 1'b0, 63, 1'b0, 32'hA1, 1'b1, 5, 1'b0, 32'h0);
    push(20, 32'hA1, 32'hDEAD, 1'b1, t + 3);
    step();
    bus.iiq_dispatch_valid = 1'b0;
    @(negedge clk);
    check("ld_wait_valid", 64'(bus.alu_issue_valid), 64'd0);
    step();
    bus.ld_broadcast_valid    = 1'b1;
    bus.ld_broadcast_rob_id   = rob_id_t'(5);
    bus.ld_broadcast_reg_data = 32'hDEAD;
    step();
    bus.ld_broadcast_valid    = 1'b0;
    step(); step();

    // Full queue: issue and dispatch together -> dispatch refused, count 7
    bus.alu_issue_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      bus.iiq_dispatch_valid = 1'b1;
      bus.iiq_dispatch_data  = mk(30 + k, 1'b0, 1'b0, 63, 1'b0, 32'h300 + 32'(k),
                                  1'b0, 63, 1'b0, 32'h400 + 32'(k));
    end
    step();
    t = cyc;
    bus.iiq_dispatch_data = mk(40, 1'b0, 1'b0, 63, 1'b0, 32'h340, 1'b0, 63, 1'b0, 32'h440);
    bus.alu_issue_ready   = 1'b1;
    push(30, 32'h300, 32'h400, 1'b0, t);
    @(negedge clk);
    check("full_issue_dispatch_ready", 64'(bus.iiq_dispatch_ready), 64'd0);
    check("full_issue_valid", 64'(bus.alu_issue_valid), 64'd1);
    step();
    bus.alu_issue_ready = 1'b0;
    @(negedge clk);
    check("after_issue_ready", 64'(bus.iiq_dispatch_ready), 64'd1);
    step();
    bus.iiq_dispatch_valid = 1'b0;
    @(negedge clk);
    check("refill_ready", 64'(bus.iiq_dispatch_ready), 64'd0);
    step();
    t = cyc;
    for (int k = 1; k < 8; k++) push(30 + k, 32'h300 + 32'(k), 32'h400 + 32'(k), 1'b0, t + k - 1);
    push(40, 32'h340, 32'h440, 1'b0, t + 7);
    bus.alu_issue_ready = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("refill_drained_valid", 64'(bus.alu_issue_valid), 64'd0);

    // Branch mispredict with 4 entries queued
    bus.alu_issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.iiq_dispatch_valid = 1'b1;
      bus.iiq_dispatch_data  = mk(50 + k, 1'b1, 1'b0, 63, 1'b0, 32'h500, 1'b0, 63, 1'b0, 32'h600);
    end
    step();
    bus.iiq_dispatch_valid = 1'b0;
    bus.alu_issue_ready    = 1'b1;
    bus.alu_br_mispred     = 1'b1;
    @(negedge clk);
    check("flush_issue_valid", 64'(bus.alu_issue_valid), 64'd0);
    check("flush_dispatch_ready", 64'(bus.iiq_dispatch_ready), 64'd0);
    step();
    t = cyc;
    bus.alu_br_mispred     = 1'b0;
    bus.iiq_dispatch_valid = 1'b1;
    bus.iiq_dispatch_data  = mk(60, 1'b1, 1'b0, 63, 1'b0, 32'h6A, 1'b0, 63, 1'b0, 32'h6B);
    push(60, 32'h6A, 32'h6B, 1'b1, t + 1);
    @(negedge clk);
    check("post_flush_valid", 64'(bus.alu_issue_valid), 64'd0);
    check("post_flush_ready", 64'(bus.iiq_dispatch_ready), 64'd1);
    step();
    bus.iiq_dispatch_valid = 1'b0;
    step(); step();

    // Reset mid-operation drops queued entries
    bus.alu_issue_ready = 1'b0;
    step();
    bus.iiq_dispatch_valid = 1'b1;
    bus.iiq_dispatch_data  = mk(70, 1'b1, 1'b0, 63, 1'b0, 32'h70, 1'b0, 63, 1'b0, 32'h71);
    step();
    bus.iiq_dispatch_data  = mk(71, 1'b1, 1'b0, 63, 1'b0, 32'h72, 1'b0, 63, 1'b0, 32'h73);
    step();
    bus.iiq_dispatch_valid = 1'b0;
    rst_aL = 1'b0;
    step();
    rst_aL = 1'b1;
    bus.alu_issue_ready = 1'b1;
    @(negedge clk);
    check("midrst_issue_valid", 64'(bus.alu_issue_valid), 64'd0);
    check("midrst_dispatch_ready", 64'(bus.iiq_dispatch_ready), 64'd1);
    repeat (3) step();

    // Every expected issue must have been seen
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("outstanding_issues", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
